apb_mem_slave_param: RTL and testbench

- Parametrised APB4 memory-mapped slave; next generation of the fixed-width APB DUT.
- Adds configurable data/address width, depth and wait states, PSTRB byte-lane writes, and pslave_error on out-of-range or misaligned access.
- Sits behind the APB interface in the same testbench, replacing the fixed DUT, and drives pready, prdata and pslave_error.

---
 rtl/apb_pkg.sv | 31 +++
 rtl/apb_byte_ram.sv | 35 +++
 rtl/apb_mem_slave_param.sv | 134 +++++++++++++
 tb/tb_apb_mem_slave_param.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and helpers for the parameterised APB memory slave.
//   apb_state_e   : transfer FSM states
//   APB_MAX_WAIT  : largest supported wait-state count (4-bit counter)
//   APB_OKAY/ERR  : pslave_error encodings
//   apb_addr_err  : out-of-range / misaligned decode for a byte address
package apb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} apb_state_e;

   localparam int   APB_MAX_WAIT = 15;
   localparam logic APB_OKAY     = 1'b0;
   localparam logic APB_ERR      = 1'b1;

   // Returns 1 when the word index is outside the memory or the address is
   // not aligned to the data width. addr is zero-extended by the caller.
   function automatic logic apb_addr_err(input logic [31:0] addr,
                                         input int unsigned addr_w,
                                         input int unsigned data_w,
                                         input int unsigned depth);
      logic [31:0] a;
      logic [31:0] idx;
      logic [31:0] amask;
      int unsigned align;
      align = (data_w == 32) ? 2 : (data_w == 16) ? 1 : 0;
      a     = (addr_w < 32) ? (addr & ((32'h1 << addr_w) - 32'h1)) : addr;
      idx   = a >> align;
      amask = (32'h1 << align) - 32'h1;
      return (idx >= depth) || ((a & amask) != 32'h0);
   endfunction

endpackage

// File: rtl/apb_byte_ram.sv
// DEPTH x DATA_WIDTH register array with per-byte write enables.
//   clk, rst_n : clock, synchronous active-low clear of every word
//   we/waddr/wstrb/wdata : byte-lane write port
//   raddr/rdata          : asynchronous read port
module apb_byte_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int IDX_W      = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [IDX_W-1:0]        waddr,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [IDX_W-1:0]        raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < NB; b++)
            if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_mem_slave_param.sv
// Parameterised APB4 memory slave with byte strobes, configurable wait
// states and pslave_error on out-of-range or misaligned accesses.
//   pclk, presetn            : clock, synchronous active-low reset
//   paddr/pselx/penable/pwrite/pwdata/pstrb : APB request
//   prdata/pready/pslave_error              : registered APB response
module apb_mem_slave_param
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic                    pselx,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslave_error
);

   localparam int NB     = DATA_WIDTH / 8;
   localparam int ALIGN  = $clog2(NB);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WS_EFF = (WAIT_STATES > APB_MAX_WAIT) ? APB_MAX_WAIT : WAIT_STATES;

   apb_state_e            state;
   logic [3:0]            wcnt;
   logic [IDX_W-1:0]      lat_idx;
   logic                  lat_write;
   logic                  lat_err;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [NB-1:0]         lat_strb;

   logic                  in_err;
   logic [IDX_W-1:0]      in_idx;
   logic [IDX_W-1:0]      rd_idx;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  ram_we;

   assign in_err = apb_addr_err(32'(paddr), ADDR_WIDTH, DATA_WIDTH, DEPTH);
   assign in_idx = IDX_W'(paddr >> ALIGN);

   // With zero wait states the response is built from the live setup-phase
   // address; afterwards only the latched index is used.
   assign rd_idx = (state == ACCESS) ? lat_idx : in_idx;

   // Memory commits on the completion edge only, and never for an error.
   assign ram_we = (state == ACCESS) && pselx && penable && pready &&
                   lat_write && !lat_err;

   apb_byte_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk   (pclk),
      .rst_n (presetn),
      .we    (ram_we),
      .waddr (lat_idx),
      .wstrb (lat_strb),
      .wdata (lat_wdata),
      .raddr (rd_idx),
      .rdata (rd_word)
   );

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state        <= IDLE;
         pready       <= 1'b0;
         prdata       <= '0;
         pslave_error <= APB_OKAY;
         wcnt         <= '0;
         lat_idx      <= '0;
         lat_write    <= 1'b0;
         lat_err      <= 1'b0;
         lat_wdata    <= '0;
         lat_strb     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               state        <= IDLE;
               pready       <= 1'b0;
               prdata       <= '0;
               pslave_error <= APB_OKAY;
               if (pselx && !penable) begin
                  state     <= ACCESS;
                  wcnt      <= 4'(WS_EFF);
                  lat_idx   <= in_idx;
                  lat_write <= pwrite;
                  lat_err   <= in_err;
                  lat_wdata <= pwdata;
                  lat_strb  <= pstrb;
                  if (WS_EFF == 0) begin
                     pready       <= 1'b1;
                     pslave_error <= in_err ? APB_ERR : APB_OKAY;
                     prdata       <= (!pwrite && !in_err) ? rd_word : '0;
                  end
               end
            end
            ACCESS: begin
               if (!pselx) begin
                  state        <= IDLE;
                  pready       <= 1'b0;
                  prdata       <= '0;
                  pslave_error <= APB_OKAY;
               end else if (penable) begin
                  if (pready) begin
                     state        <= DONE;
                     pready       <= 1'b0;
                     prdata       <= '0;
                     pslave_error <= APB_OKAY;
                  end else begin
                     // Response lands on the edge that takes the count 1 -> 0.
                     wcnt <= wcnt - 4'd1;
                     if (wcnt <= 4'd1) begin
                        pready       <= 1'b1;
                        pslave_error <= lat_err ? APB_ERR : APB_OKAY;
                        prdata       <= (!lat_write && !lat_err) ? rd_word : '0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Bench for apb_mem_slave_param: three instances (0, 2 and 3 wait states)
// on private buses, a transaction-level model of expected outputs checked
// every cycle, and literal pins on the interesting transfers.
module tb_apb_mem_slave_param;
   import apb_pkg::*;

   function automatic int ws_of(input int d);
      case (d)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   logic        pclk;
   logic        presetn;
   logic [7:0]  paddr   [3];
   logic        psel    [3];
   logic        penable [3];
   logic        pwrite  [3];
   logic [31:0] pwdata  [3];
   logic [3:0]  pstrb   [3];
   logic [31:0] prdata  [3];
   logic        pready  [3];
   logic        perr    [3];

   // expected outputs for the current cycle, maintained by the driver
   logic        e_rdy   [3];
   logic [31:0] e_rd    [3];
   logic        e_err   [3];
   logic        e_rd_on [3];
   logic [31:0] mem     [3][32];

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_mem_slave_param #(
         .ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(32), .WAIT_STATES(ws_of(g))
      ) u_dut (
         .pclk         (pclk),
         .presetn      (presetn),
         .paddr        (paddr[g]),
         .pselx        (psel[g]),
         .penable      (penable[g]),
         .pwrite       (pwrite[g]),
         .pwdata       (pwdata[g]),
         .pstrb        (pstrb[g]),
         .prdata       (prdata[g]),
         .pready       (pready[g]),
         .pslave_error (perr[g])
      );
   end

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   always @(negedge pclk) begin
      if (chk_en) begin
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("pready[%0d]", d), 32'(pready[d]), 32'(e_rdy[d]));
            chk($sformatf("perr[%0d]", d), 32'(perr[d]), 32'(e_err[d]));
            if (e_rd_on[d]) chk($sformatf("prdata[%0d]", d), prdata[d], e_rd[d]);
         end
      end
   end

   task automatic clear_exp();
      for (int d = 0; d < 3; d++) begin
         e_rdy[d] = 1'b0; e_rd[d] = '0; e_err[d] = 1'b0; e_rd_on[d] = 1'b1;
      end
   endtask

   task automatic clear_mem();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 32; i++) mem[d][i] = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge pclk); #1; end
   endtask

   // Starts just after an edge; returns just after the completion edge with
   // the bus released, so a following call gives a back-to-back transfer.
   // abort_at / rst_at: access cycle (1-based) in which pselx drops or
   // presetn is asserted; 0 disables.
   task automatic xfer(input int d, input logic [7:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] st,
                       input int abort_at, input int rst_at,
                       output logic [31:0] got_rd, output logic got_err);
      int   ws;
      int   idx;
      logic err;
      ws  = ws_of(d);
      idx = int'(a) / 4;
      err = (idx >= 32) || (a[1:0] != 2'b00);
      got_rd = '0; got_err = 1'b0;
      paddr[d] = a; pwrite[d] = w; pwdata[d] = wd; pstrb[d] = st;
      psel[d] = 1'b1; penable[d] = 1'b0;
      @(posedge pclk); #1;
      penable[d] = 1'b1;
      paddr[d] = ~a; pwdata[d] = ~wd;   // only the setup-phase values may matter
      for (int k = 1; k <= ws + 1; k++) begin
         if (k == ws + 1) begin
            e_rdy[d]   = 1'b1;
            e_err[d]   = err;
            e_rd_on[d] = !w;
            e_rd[d]    = (!w && !err) ? mem[d][idx] : 32'h0;
         end
         if (abort_at == k) begin psel[d] = 1'b0; penable[d] = 1'b0; end
         if (rst_at == k) presetn = 1'b0;
         @(negedge pclk);
         got_rd = prdata[d]; got_err = perr[d];
         @(posedge pclk); #1;
         if (abort_at == k || rst_at == k) begin
            if (rst_at == k) begin clear_mem(); presetn = 1'b1; end
            clear_exp();
            psel[d] = 1'b0; penable[d] = 1'b0;
            return;
         end
      end
      if (w && !err)
         for (int b = 0; b < 4; b++)
            if (st[b]) mem[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      clear_exp();
      psel[d] = 1'b0; penable[d] = 1'b0;
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      presetn = 1'b0;
      for (int d = 0; d < 3; d++) begin
         paddr[d] = '0; psel[d] = 1'b0; penable[d] = 1'b0;
         pwrite[d] = 1'b0; pwdata[d] = '0; pstrb[d] = '0;
      end
      clear_exp();
      clear_mem();
      @(posedge pclk); #1;
      for (int d = 0; d < 3; d++) begin
         chk("rst_pready", 32'(pready[d]), 32'h0);
         chk("rst_prdata", prdata[d], 32'h0);
         chk("rst_perr", 32'(perr[d]), 32'h0);
      end
      chk_en  = 1'b1;
      presetn = 1'b1;

      // basic write/read, zero wait states
      xfer(0, 8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 0, 0, rd, er);
      chk("wr04_err", 32'(er), 32'h0);
      xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("rd04", rd, 32'hDEADBEEF);

      // byte strobes
      xfer(0, 8'h04, 1'b1, 32'h11223344, 4'b0101, 0, 0, rd, er);
      chk("model_strb", mem[0][1], 32'hDE22BE44);
      xfer(0, 8'h04, 1'b0, 32'h0, 4'hF, 0, 0, rd, er);
      chk("rd04_strb", rd, 32'hDE22BE44);

      // three wait states
      idle(1);
      xfer(2, 8'h00, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("ws3_rd00", rd, 32'h0);
      chk("ws3_err", 32'(er), 32'h0);

      // out of range write (index 32 would alias word 0 if truncated)
      xfer(0, 8'h80, 1'b1, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er);
      chk("wr80_err", 32'(er), 32'h1);
      xfer(0, 8'h00, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("rd00_after_err", rd, 32'h0);

      // misaligned read
      xfer(0, 8'h06, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("rd06_err", 32'(er), 32'h1);
      chk("rd06_data", rd, 32'h0);

      // back-to-back write then read, no idle cycles
      xfer(0, 8'h08, 1'b1, 32'hA5A5A5A5, 4'hF, 0, 0, rd, er);
      xfer(0, 8'h08, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("b2b_rd08", rd, 32'hA5A5A5A5);

      // abort mid-access with two wait states
      idle(1);
      xfer(1, 8'h0C, 1'b1, 32'hDEADBEEF, 4'hF, 2, 0, rd, er);
      xfer(1, 8'h0C, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("abort_rd0c", rd, 32'h0);
      xfer(1, 8'h0C, 1'b1, 32'h12345678, 4'hF, 0, 0, rd, er);
      xfer(1, 8'h0C, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("ws2_rd0c", rd, 32'h12345678);

      // penable high while idle must be ignored
      psel[0] = 1'b1; penable[0] = 1'b1;
      idle(2);
      psel[0] = 1'b0; penable[0] = 1'b0;
      idle(1);

      // back-to-back with wait states and a single-lane strobe
      xfer(2, 8'h1C, 1'b1, 32'h55AABBCC, 4'b1000, 0, 0, rd, er);
      xfer(2, 8'h1C, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("ws3_rd1c", rd, 32'h55000000);

      // reset during the access phase of a write (completion cycle for ws=0)
      xfer(0, 8'h10, 1'b1, 32'hCAFEF00D, 4'hF, 0, 1, rd, er);
      xfer(0, 8'h10, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("rst_rd10", rd, 32'h0);
      xfer(0, 8'h04, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("rst_rd04", rd, 32'h0);
      xfer(2, 8'h1C, 1'b0, 32'h0, 4'h0, 0, 0, rd, er);
      chk("rst_rd1c", rd, 32'h0);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
